// File: rtl/div_datapath.sv
// Datapath for the sequential non-restoring unsigned divider: holds R, Q, D and the
// registered results, and reports the partial-remainder sign back to the controller.
module div_datapath #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             add_i,
   input  logic [1:0]       sel_i,
   input  logic             shift_i,
   input  logic             inbit_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             sign_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   typedef enum logic [1:0] {
      SEL_HOLD    = 2'b00,
      SEL_ITERATE = 2'b01,
      SEL_IDLE    = 2'b10,
      SEL_FINISH  = 2'b11
   } sel_e;

   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH-1:0] q_shift;
   sel_e             sel;

   assign d_ext = {1'b0, d_q};
   assign sel   = sel_e'(sel_i);

   // Operand load has priority over the controller's sel decode; results are captured
   // from the post-update R/Q so valid can ride on the finish cycle itself.
   always_comb begin
      r_d        = r_q;
      q_d        = q_q;
      d_d        = d_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_zero_d = div_zero_q;
      r_shift    = r_q;
      q_shift    = q_q;

      if (load_i) begin
         r_d        = '0;
         q_d        = dividend_i;
         d_d        = divisor_i;
         div_zero_d = (divisor_i == '0);
      end else begin
         if (shift_i) begin
            r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
            q_shift = {q_q[WIDTH-2:0], inbit_i};
         end
         case (sel)
            SEL_ITERATE: begin
               r_d = add_i ? (r_shift + d_ext) : (r_shift - d_ext);
               q_d = q_shift;
            end
            // Final quotient bit goes in; a negative remainder is corrected by adding D back.
            SEL_FINISH: begin
               q_d = q_shift;
               r_d = add_i ? (r_q + d_ext) : r_q;
            end
            default: begin
            end
         endcase
         if (valid_i) begin
            quot_d = q_d;
            rem_d  = r_d[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         div_zero_q <= 1'b0;
      end else begin
         r_q        <= r_d;
         q_q        <= q_d;
         d_q        <= d_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign sign_o      = r_q[WIDTH];
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: plays the controller protocol and compares
// results against plain integer division computed in the bench.
module tb_div_datapath;

   localparam int W = 8;

   logic         clk;
   logic         resetN;
   logic         load;
   logic         add;
   logic [1:0]   sel;
   logic         shift;
   logic         inbit;
   logic         valid;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         sign;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         divZero;

   int nChecks = 0;
   int nFails  = 0;

   div_datapath #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .reset_i     (resetN),
      .load_i      (load),
      .add_i       (add),
      .sel_i       (sel),
      .shift_i     (shift),
      .inbit_i     (inbit),
      .valid_i     (valid),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .sign_o      (sign),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .div_zero_o  (divZero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goIdle();
      load  = 1'b0;
      sel   = 2'b10;
      shift = 1'b0;
      add   = 1'b0;
      inbit = 1'b0;
      valid = 1'b0;
   endtask

   task automatic doLoad(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
      goIdle();
      load     = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      tick();
      load = 1'b0;
   endtask

   // Controller behaviour for iterations first..last (1-based).
   task automatic doIterations(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         sel   = 2'b01;
         shift = 1'b1;
         valid = 1'b0;
         if (i == 1) begin
            add   = 1'b0;
            inbit = 1'($urandom_range(0, 1));
         end else begin
            add   = sign;
            inbit = ~sign;
         end
         tick();
      end
   endtask

   task automatic doFinish(input logic withValid);
      sel   = 2'b11;
      shift = 1'b1;
      add   = sign;
      inbit = ~sign;
      valid = withValid;
      tick();
      goIdle();
   endtask

   task automatic runDivision(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                              input logic withValid);
      doLoad(dvd, dvs);
      doIterations(1, W);
      doFinish(withValid);
   endtask

   task automatic test_reset();
      load     = 1'b1;
      add      = 1'b1;
      sel      = 2'b11;
      shift    = 1'b1;
      inbit    = 1'b1;
      valid    = 1'b1;
      dividend = 8'hA5;
      divisor  = 8'h00;
      resetN   = 1'b0;
      tick();
      resetN = 1'b1;
      goIdle();
      for (int c = 0; c <= 5; c++) begin
         nChecks++;
         if ({quotient, remainder, divZero, sign} !== '0) begin
            nFails++;
            $display("[TB] FAIL reset cycle %0d: q=%0d r=%0d dz=%0b sign=%0b, want all 0",
                     c, quotient, remainder, divZero, sign);
         end
         tick();
      end
   endtask

   // Runs one full division and compares against integer arithmetic.
   task automatic test_division(input string name, input logic [W-1:0] dvd,
                                input logic [W-1:0] dvs);
      logic [W-1:0] expQ;
      logic [W-1:0] expR;
      logic         expZ;
      expZ = (dvs == 0);
      expQ = expZ ? {W{1'b1}} : W'(int'(dvd) / int'(dvs));
      expR = expZ ? dvd : W'(int'(dvd) % int'(dvs));
      runDivision(dvd, dvs, 1'b1);
      nChecks++;
      if (quotient !== expQ) begin
         nFails++;
         $display("[TB] FAIL %s quotient %0d/%0d: got %0d want %0d", name, dvd, dvs, quotient, expQ);
      end
      nChecks++;
      if (remainder !== expR) begin
         nFails++;
         $display("[TB] FAIL %s remainder %0d/%0d: got %0d want %0d", name, dvd, dvs, remainder, expR);
      end
      nChecks++;
      if (divZero !== expZ) begin
         nFails++;
         $display("[TB] FAIL %s div_zero %0d/%0d: got %0b want %0b", name, dvd, dvs, divZero, expZ);
      end
   endtask

   task automatic test_edges();
      test_division("nominal", 8'd100, 8'd7);
      test_division("max_by_one", 8'd255, 8'd1);
      test_division("small_by_big", 8'd5, 8'd9);
      test_division("max_by_max", 8'd255, 8'd255);
      test_division("zero_dividend", 8'd0, 8'd3);
      test_division("div_by_zero", 8'd100, 8'd0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         test_division("random", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_reset_mid_division();
      test_division("pre_reset", 8'd100, 8'd7);
      doLoad(8'd200, 8'd13);
      doIterations(1, 4);
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      goIdle();
      nChecks++;
      if ({quotient, remainder, divZero, sign} !== '0) begin
         nFails++;
         $display("[TB] FAIL mid_reset: q=%0d r=%0d dz=%0b sign=%0b, want all 0",
                  quotient, remainder, divZero, sign);
      end
   endtask

   task automatic test_load_mid_division();
      doLoad(8'd200, 8'd13);
      doIterations(1, 3);
      test_division("reload", 8'd50, 8'd6);
   endtask

   task automatic test_valid_isolation();
      test_division("baseline", 8'd100, 8'd7);
      runDivision(8'd60, 8'd9, 1'b0);
      for (int c = 0; c < 3; c++) begin
         nChecks++;
         if (quotient !== 8'd14 || remainder !== 8'd2) begin
            nFails++;
            $display("[TB] FAIL hold_no_valid: q=%0d r=%0d want 14/2", quotient, remainder);
         end
         tick();
      end
      valid = 1'b1;
      sel   = 2'b10;
      tick();
      valid = 1'b0;
      nChecks++;
      if (quotient !== 8'd6 || remainder !== 8'd6) begin
         nFails++;
         $display("[TB] FAIL valid_alone: q=%0d r=%0d want 6/6", quotient, remainder);
      end
   endtask

   task automatic test_back_to_back();
      test_division("b2b_a", 8'd77, 8'd10);
      test_division("b2b_b", 8'd128, 8'd128);
      test_division("b2b_c", 8'd254, 8'd2);
   endtask

   initial begin
      resetN   = 1'b1;
      dividend = '0;
      divisor  = '0;
      goIdle();
      test_reset();
      test_edges();
      test_reset_mid_division();
      test_load_mid_division();
      test_valid_isolation();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
